// File: rtl/rdma_pkt_fifo.sv
// rdma_pkt_fifo: store-and-forward packet buffer between the RDMA RX and TX
// beat streams. Beats are written as they arrive. A packet becomes readable
// only after its last beat is stored. A packet that cannot fit is tail-dropped
// as a whole, so downstream only ever sees complete packets.
module rdma_pkt_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_last,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_last,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]    DEPTH_P  = PW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Storage: {last, data} per entry
    logic [DATA_W:0]    mem_r [DEPTH];

    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      commit_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic               dropping_r;
    logic [PW-1:0]      pkt_count_r;
    logic [CNT_W-1:0]   drop_count_r;
    logic [PW-1:0]      fill_level_r;
    logic               tx_valid_r;
    logic [DATA_W-1:0]  tx_data_r;
    logic               tx_last_r;

    logic [PW-1:0]      used_s;
    logic               full_s;
    logic [PW-1:0]      wr_nxt_s;
    logic [PW-1:0]      commit_nxt_s;
    logic               dropping_nxt_s;
    logic               mem_we_s;
    logic               pkt_inc_s;
    logic               drop_inc_s;
    logic               tx_hs_s;
    logic [PW-1:0]      rd_nxt_s;
    logic               pkt_dec_s;
    logic               ld_valid_s;
    logic [DATA_W:0]    rd_word_s;
    logic [PW-1:0]      pkt_nxt_s;

    // Fullness uses the pointers from before this edge, so a read in the
    // same cycle never rescues a beat that arrives on a full buffer.
    always_comb begin
        used_s = wr_ptr_r - rd_ptr_r;
        full_s = (used_s == DEPTH_P);
    end

    // RX decision: store, tail-drop the partial packet, or discard while dropping
    always_comb begin
        wr_nxt_s       = wr_ptr_r;
        commit_nxt_s   = commit_ptr_r;
        dropping_nxt_s = dropping_r;
        mem_we_s       = 1'b0;
        pkt_inc_s      = 1'b0;
        drop_inc_s     = 1'b0;
        if (rx_valid) begin
            if (dropping_r) begin
                if (rx_last) begin
                    dropping_nxt_s = 1'b0;
                    drop_inc_s     = 1'b1;
                end else begin
                    dropping_nxt_s = 1'b1;
                end
            end else if (!full_s) begin
                mem_we_s = 1'b1;
                wr_nxt_s = wr_ptr_r + PTR_ONE;
                if (rx_last) begin
                    commit_nxt_s = wr_ptr_r + PTR_ONE;
                    pkt_inc_s    = 1'b1;
                end else begin
                    commit_nxt_s = commit_ptr_r;
                end
            end else begin
                // Rewind to the last committed packet boundary
                wr_nxt_s = commit_ptr_r;
                if (rx_last) begin
                    drop_inc_s = 1'b1;
                end else begin
                    dropping_nxt_s = 1'b1;
                end
            end
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
    end

    // TX side: rd_ptr addresses the beat currently shown on the output
    // register. Only commits from earlier edges are visible, which gives the
    // one-cycle gap between the rx_last edge and the rising tx_valid.
    always_comb begin
        tx_hs_s    = tx_valid_r & tx_ready;
        pkt_dec_s  = tx_hs_s & tx_last_r;
        if (tx_hs_s) begin
            rd_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        ld_valid_s = (rd_nxt_s != commit_ptr_r);
        rd_word_s  = mem_r[rd_nxt_s[AW-1:0]];
    end

    // Packet count: a commit and a last-beat handshake in one cycle cancel
    always_comb begin
        case ({pkt_inc_s, pkt_dec_s})
            2'b10:   pkt_nxt_s = pkt_count_r + PTR_ONE;
            2'b01:   pkt_nxt_s = pkt_count_r - PTR_ONE;
            default: pkt_nxt_s = pkt_count_r;
        endcase
    end

    // Beat storage write port
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {rx_last, rx_data};
        end
    end

    // Pointers, flags, counters and the fall-through output register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            commit_ptr_r <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            dropping_r   <= 1'b0;
            pkt_count_r  <= {PW{1'b0}};
            drop_count_r <= {CNT_W{1'b0}};
            fill_level_r <= {PW{1'b0}};
            tx_valid_r   <= 1'b0;
            tx_data_r    <= {DATA_W{1'b0}};
            tx_last_r    <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_nxt_s;
            commit_ptr_r <= commit_nxt_s;
            rd_ptr_r     <= rd_nxt_s;
            dropping_r   <= dropping_nxt_s;
            pkt_count_r  <= pkt_nxt_s;
            fill_level_r <= wr_nxt_s - rd_nxt_s;
            if (drop_inc_s && (drop_count_r != CNT_MAX)) begin
                drop_count_r <= drop_count_r + CNT_ONE;
            end else begin
                drop_count_r <= drop_count_r;
            end
            tx_valid_r <= ld_valid_s;
            if (ld_valid_s) begin
                tx_data_r <= rd_word_s[DATA_W-1:0];
                tx_last_r <= rd_word_s[DATA_W];
            end else begin
                tx_data_r <= {DATA_W{1'b0}};
                tx_last_r <= 1'b0;
            end
        end
    end

    assign tx_valid   = tx_valid_r;
    assign tx_data    = tx_data_r;
    assign tx_last    = tx_last_r;
    assign pkt_count  = pkt_count_r;
    assign drop_count = drop_count_r;
    assign fill_level = fill_level_r;

endmodule
